receiver: RTL and testbench

Serial receive engine for the serial IP: the counterpart of the transmit engine on the same line protocol. Oversamples the asynchronous `in` line at 16× baud using ticks from the shared baud-rate generator (`brgen`). Recovers 5–8 data bits, an optional parity or ninth bit, and 1 or 2 stop bits. Pushes each received word plus error flags into the RX FIFO with a one-cycle write strobe.

---
 rtl/serial_pkg.sv | 38 +++
 rtl/receiver_if.sv | 28 ++
 rtl/rx_sync.sv | 40 ++++
 rtl/receiver.sv | 195 +++++++++++++++++++
 tb/tb_receiver.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared encodings for the serial IP (receiver and transmitter).
//   PAR_*   : parity field of the control register
//   SIZE_*  : data-bit-count field of the control register
//   rx_state_e / tx_state_e : frame engine states
package serial_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_BIT9 = 2'b11;

  localparam logic [1:0] SIZE_5 = 2'b00;
  localparam logic [1:0] SIZE_6 = 2'b01;
  localparam logic [1:0] SIZE_7 = 2'b10;
  localparam logic [1:0] SIZE_8 = 2'b11;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP1, RX_STOP2
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_e;

  // Index of the last data bit for a given size field (4..7).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] size);
    logic [2:0] idx;
    case (size)
      SIZE_5:  idx = 3'd4;
      SIZE_6:  idx = 3'd5;
      SIZE_7:  idx = 3'd6;
      SIZE_8:  idx = 3'd7;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/receiver_if.sv
// Receiver bus: configuration, serial line and RX FIFO push side.
//   slave  : the receiver (consumes config/line, produces word + strobes)
//   master : the surrounding IP / testbench
interface receiver_if;
  logic       brgen;
  logic       enable;
  logic       full;
  logic [1:0] size;
  logic       stop2;
  logic [1:0] parity;
  logic       in;
  logic [8:0] data;
  logic       data_write;
  logic       parity_error;
  logic       framing_error;
  logic       overflow;
  logic       busy;

  modport slave (
    input  brgen, enable, full, size, stop2, parity, in,
    output data, data_write, parity_error, framing_error, overflow, busy
  );

  modport master (
    output brgen, enable, full, size, stop2, parity, in,
    input  data, data_write, parity_error, framing_error, overflow, busy
  );
endinterface

// File: rtl/rx_sync.sv
// Input conditioning for the receiver.
//   clk, reset : system clock, async active-low reset
//   in_i       : asynchronous serial line (idle high)
//   brgen_i    : baud generator output
//   rxs_o      : synchronized line
//   tick_o     : one-clk pulse per brgen rising edge (registered)
module rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  input  logic brgen_i,
  output logic rxs_o,
  output logic tick_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   brgen_q;
  logic                   tick_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; blocking here would collapse the chain into one stage.
  // The chain resets to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '1;
      brgen_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_i};
      brgen_q <= brgen_i;
      tick_q  <= brgen_i & ~brgen_q;
    end
  end

  assign rxs_o  = sync_q[SYNC_STAGES-1];
  assign tick_o = tick_q;

endmodule

// File: rtl/receiver.sv
// Serial receive engine: 16x oversampled start/data/parity/stop recovery,
// pushing each word plus error flags into the RX FIFO.
//   clk, reset : system clock, async active-low reset
//   bus        : receiver_if.slave (config, line, FIFO push, status)
module receiver
  import serial_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  receiver_if.slave   bus
);

  localparam int            TW    = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

  logic rxs;
  logic tick;

  rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .in_i    (bus.in),
    .brgen_i (bus.brgen),
    .rxs_o   (rxs),
    .tick_o  (tick)
  );

  rx_state_e     state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [8:0]    word_q, word_d;      // word being assembled
  logic          perr_acc_q, perr_acc_d;
  logic          ferr_acc_q, ferr_acc_d;
  logic [8:0]    data_q, data_d;      // last delivered word
  logic          data_write_q, data_write_d;
  logic          parity_error_q, parity_error_d;
  logic          framing_error_q, framing_error_d;
  logic          overflow_q, overflow_d;
  logic          frame_done;
  logic          at_end;

  assign at_end = (tcnt_q == T_END);

  // NOTE: every variable written below gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    tcnt_d          = tcnt_q;
    bitn_d          = bitn_q;
    word_d          = word_q;
    perr_acc_d      = perr_acc_q;
    ferr_acc_d      = ferr_acc_q;
    data_d          = data_q;
    data_write_d    = 1'b0;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;
    overflow_d      = 1'b0;
    frame_done      = 1'b0;

    if (!bus.enable) begin
      // Frame in progress is discarded; synchronizer keeps running.
      state_d = RX_IDLE;
      tcnt_d  = '0;
      bitn_d  = '0;
    end else if (tick) begin
      case (state_q)
        RX_IDLE: begin
          if (!rxs) begin
            state_d = RX_START;
            tcnt_d  = '0;
          end
        end
        RX_START: begin
          if (tcnt_q == T_MID) begin
            if (rxs) begin
              state_d = RX_IDLE;          // glitch, not a start bit
            end else begin
              state_d    = RX_DATA;
              tcnt_d     = '0;
              bitn_d     = '0;
              word_d     = '0;
              perr_acc_d = 1'b0;
              ferr_acc_d = 1'b0;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (at_end) begin
            tcnt_d         = '0;
            word_d[bitn_q] = rxs;
            // >= keeps the frame finite if size shrinks mid-frame.
            if (bitn_q >= last_bit_idx(bus.size)) begin
              state_d = (bus.parity != PAR_NONE) ? RX_PARITY : RX_STOP1;
            end else begin
              bitn_d = bitn_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        RX_PARITY: begin
          if (at_end) begin
            tcnt_d  = '0;
            state_d = RX_STOP1;
            case (bus.parity)
              PAR_EVEN: perr_acc_d = (^word_q[7:0]) ^ rxs;
              PAR_ODD:  perr_acc_d = ~((^word_q[7:0]) ^ rxs);
              PAR_BIT9: word_d[8]  = rxs;
              default:  perr_acc_d = 1'b0;
            endcase
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        RX_STOP1: begin
          if (at_end) begin
            tcnt_d = '0;
            if (!rxs) ferr_acc_d = 1'b1;
            if (bus.stop2) begin
              state_d = RX_STOP2;
            end else begin
              state_d    = RX_IDLE;       // mid-stop: ready for next start
              frame_done = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        RX_STOP2: begin
          if (at_end) begin
            tcnt_d     = '0;
            state_d    = RX_IDLE;
            frame_done = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end

    if (frame_done) begin
      if (!bus.full) begin
        data_write_d    = 1'b1;
        data_d          = word_q;
        parity_error_d  = perr_acc_q;
        framing_error_d = ferr_acc_q | ~rxs;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= RX_IDLE;
      tcnt_q          <= '0;
      bitn_q          <= '0;
      word_q          <= '0;
      perr_acc_q      <= 1'b0;
      ferr_acc_q      <= 1'b0;
      data_q          <= '0;
      data_write_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      tcnt_q          <= tcnt_d;
      bitn_q          <= bitn_d;
      word_q          <= word_d;
      perr_acc_q      <= perr_acc_d;
      ferr_acc_q      <= ferr_acc_d;
      data_q          <= data_d;
      data_write_q    <= data_write_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      overflow_q      <= overflow_d;
    end
  end

  assign bus.data          = data_q;
  assign bus.data_write    = data_write_q;
  assign bus.parity_error  = parity_error_q;
  assign bus.framing_error = framing_error_q;
  assign bus.overflow      = overflow_q;
  assign bus.busy          = (state_q != RX_IDLE);

endmodule

// File: tb/tb_receiver.sv
// Directed testbench for the serial receiver.
module tb_receiver;

  localparam int BIT_CLK = 64;   // 16 ticks x 4 clk per tick

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   wr_cnt  = 0;
  int   ovf_cnt = 0;

  typedef struct packed {
    logic       pe;
    logic       fe;
    logic [8:0] d;
  } wr_t;

  wr_t wq[$];

  receiver_if bus ();

  receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // One tick every 4 clk, high for one clk, edges away from posedge.
  initial begin
    bus.brgen = 1'b0;
    forever begin
      #30 bus.brgen = 1'b1;
      #10 bus.brgen = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.data_write) begin
      wq.push_back(wr_t'{pe: bus.parity_error, fe: bus.framing_error, d: bus.data});
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.overflow) ovf_cnt <= ovf_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int nclk);
    bus.in = v;
    repeat (nclk) @(negedge clk);
  endtask

  // Start bit, n data bits LSB first, optional parity, stop bit(s).
  // A low second stop bit is held low for 10 ticks only, then released.
  task automatic send_frame(input logic [7:0] d, input int n, input logic has_par,
                            input logic pbit, input int nstop, input logic last_stop);
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < n; i++) drive_bit(d[i], BIT_CLK);
    if (has_par) drive_bit(pbit, BIT_CLK);
    drive_bit(1'b1, BIT_CLK);
    if (nstop == 2) begin
      if (last_stop) begin
        drive_bit(1'b1, BIT_CLK);
      end else begin
        drive_bit(1'b0, 40);
        drive_bit(1'b1, 24);
      end
    end
  endtask

  task automatic expect_write(input string tag, input logic [8:0] d,
                              input logic pe, input logic fe);
    int  waited;
    wr_t w;
    waited = 0;
    while (wq.size() == 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_count"}, 16'(wq.size()), 16'd1);
    if (wq.size() != 0) begin
      w = wq.pop_front();
      check({tag, "_data"}, 16'(w.d), 16'(d));
      check({tag, "_perr"}, 16'(w.pe), 16'(pe));
      check({tag, "_ferr"}, 16'(w.fe), 16'(fe));
    end
  endtask

  initial begin
    bus.in     = 1'b1;
    bus.enable = 1'b0;
    bus.full   = 1'b0;
    bus.size   = 2'b11;
    bus.parity = 2'b00;
    bus.stop2  = 1'b0;
    repeat (5) @(negedge clk);

    // Reset values
    check("rst_data",  16'(bus.data), 16'h0);
    check("rst_write", 16'(bus.data_write), 16'h0);
    check("rst_perr",  16'(bus.parity_error), 16'h0);
    check("rst_ferr",  16'(bus.framing_error), 16'h0);
    check("rst_ovf",   16'(bus.overflow), 16'h0);
    check("rst_busy",  16'(bus.busy), 16'h0);

    reset      = 1'b1;
    bus.enable = 1'b1;
    repeat (20) @(negedge clk);

    // 8N1, 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    expect_write("8n1_a5", 9'h0A5, 1'b0, 1'b0);
    repeat (BIT_CLK) @(negedge clk);

    // 7E1, 0x41 has two ones: even parity bit is 0, so 0 is clean and 1 errors
    bus.size = 2'b10; bus.parity = 2'b01;
    send_frame(8'h41, 7, 1'b1, 1'b0, 1, 1'b1);
    expect_write("7e1_good", 9'h041, 1'b0, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1, 1'b1);
    expect_write("7e1_bad", 9'h041, 1'b1, 1'b0);
    repeat (BIT_CLK) @(negedge clk);

    // 5O2, 0x15 (three ones, odd parity bit 0), second stop bit low
    bus.size = 2'b00; bus.parity = 2'b10; bus.stop2 = 1'b1;
    send_frame(8'h15, 5, 1'b1, 1'b0, 2, 1'b0);
    expect_write("5o2_ferr", 9'h015, 1'b0, 1'b1);
    repeat (3 * BIT_CLK) @(negedge clk);
    check("5o2_busy_after", 16'(bus.busy), 16'h0);
    check("5o2_no_extra", 16'(wq.size()), 16'h0);

    // Ninth bit capture, then a 6-tick glitch
    bus.size = 2'b11; bus.parity = 2'b11; bus.stop2 = 1'b0;
    send_frame(8'h3C, 8, 1'b1, 1'b1, 1, 1'b1);
    expect_write("bit9", 9'h13C, 1'b0, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    drive_bit(1'b0, 24);
    check("glitch_busy_mid", 16'(bus.busy), 16'h1);
    drive_bit(1'b1, 200);
    check("glitch_busy_end", 16'(bus.busy), 16'h0);
    check("glitch_no_write", 16'(wq.size()), 16'h0);

    // FIFO full: dropped word, one overflow pulse
    bus.parity = 2'b00;
    bus.full   = 1'b1;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    bus.full = 1'b0;
    check("full_no_write", 16'(wq.size()), 16'h0);
    check("full_ovf_once", 16'(ovf_cnt), 16'd1);

    // Back-to-back frames, no idle gap
    send_frame(8'h01, 8, 1'b0, 1'b0, 1, 1'b1);
    expect_write("b2b_first", 9'h001, 1'b0, 1'b0);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1, 1'b1);
    expect_write("b2b_second", 9'h0FF, 1'b0, 1'b0);
    repeat (BIT_CLK) @(negedge clk);

    // Disabled receiver ignores the line
    bus.enable = 1'b0;
    send_frame(8'h33, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    check("dis_no_write", 16'(wq.size()), 16'h0);
    check("dis_busy", 16'(bus.busy), 16'h0);
    bus.enable = 1'b1;
    repeat (BIT_CLK) @(negedge clk);

    // Reset in the middle of the data bits
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b1, BIT_CLK);
    drive_bit(1'b0, 32);
    check("mid_busy", 16'(bus.busy), 16'h1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_data",  16'(bus.data), 16'h0);
    check("mid_rst_write", 16'(bus.data_write), 16'h0);
    check("mid_rst_perr",  16'(bus.parity_error), 16'h0);
    check("mid_rst_ferr",  16'(bus.framing_error), 16'h0);
    check("mid_rst_busy",  16'(bus.busy), 16'h0);
    bus.in = 1'b1;
    reset  = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("mid_no_partial", 16'(wq.size()), 16'h0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
    expect_write("after_rst", 9'h05A, 1'b0, 1'b0);
    repeat (2 * BIT_CLK) @(negedge clk);

    check("total_writes", 16'(wr_cnt), 16'd8);
    check("total_ovf", 16'(ovf_cnt), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
